// File: rtl/issue_pkg.sv
// Shared types for the issue/dispatch slice: functional class encoding,
// opcode decode helpers and the registered dispatch packet layout.
package issue_pkg;

    // Default configuration; the dispatch packet below is sized from it.
    localparam int DEF_ROB_DEPTH = 8;
    localparam int DEF_NUM_REGS  = 16;
    localparam int DEF_FUNC_W    = 4;
    localparam int PKT_IDX_W     = $clog2(DEF_ROB_DEPTH);
    localparam int PKT_FUNC_W    = DEF_FUNC_W;

    localparam int NUM_CLASSES = 3;

    // Any opcode with this bit set is illegal.
    localparam logic [3:0] ILLEGAL_OP_MASK = 4'b1000;

    typedef enum logic [1:0] {
        CLS_ADD = 2'd0,
        CLS_MUL = 2'd1,
        CLS_BCH = 2'd2
    } issue_class_e;

    typedef struct packed {
        issue_class_e          cls;
        logic [PKT_FUNC_W-1:0] func;
        logic [PKT_IDX_W-1:0]  rob_idx;
        logic [PKT_IDX_W-1:0]  rs1_tag;
        logic                  rs1_busy;
        logic [PKT_IDX_W-1:0]  rs2_tag;
        logic                  rs2_busy;
    } disp_pkt_t;

    function automatic logic func_is_illegal(input logic [3:0] op);
        return |(op & ILLEGAL_OP_MASK);
    endfunction

    // 000x ADD, 001x MUL, 01xx BCH; the illegal range is filtered separately.
    function automatic issue_class_e func_class(input logic [3:0] op);
        if (op[2])      return CLS_BCH;
        else if (op[1]) return CLS_MUL;
        else            return CLS_ADD;
    endfunction

endpackage

// File: rtl/issue_dispatch_unit_rat.sv
// Register alias table: per architectural register a {busy, tag} pair naming
// the youngest in-flight ROB entry that will write it. Two combinational read
// ports, one rename write, one commit clear that only fires if the register
// still points at the committing entry. Rename has priority over the clear.
module issue_rat
    import issue_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int IDX_W    = PKT_IDX_W,
    parameter int REG_W    = $clog2(NUM_REGS)
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             flush,
    input  logic [REG_W-1:0] rd1_addr,
    output logic             rd1_busy,
    output logic [IDX_W-1:0] rd1_tag,
    input  logic [REG_W-1:0] rd2_addr,
    output logic             rd2_busy,
    output logic [IDX_W-1:0] rd2_tag,
    input  logic             ren_en,
    input  logic [REG_W-1:0] ren_addr,
    input  logic [IDX_W-1:0] ren_tag,
    input  logic             clr_en,
    input  logic [REG_W-1:0] clr_addr,
    input  logic [IDX_W-1:0] clr_tag
);

    logic             busy_q [NUM_REGS];
    logic [IDX_W-1:0] tag_q  [NUM_REGS];

    assign rd1_busy = busy_q[rd1_addr];
    assign rd1_tag  = tag_q[rd1_addr];
    assign rd2_busy = busy_q[rd2_addr];
    assign rd2_tag  = tag_q[rd2_addr];

    // Table update: flush clears all busy bits; otherwise commit clear then rename.
    // NOTE: non-blocking assignments let the later rename write override the
    // commit clear to the same register without any read-after-write hazard.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                busy_q[r] <= 1'b0;
                tag_q[r]  <= '0;
            end
        end else if (flush) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                busy_q[r] <= 1'b0;
            end
        end else begin
            if (clr_en && (tag_q[clr_addr] == clr_tag)) begin
                busy_q[clr_addr] <= 1'b0;
            end
            if (ren_en) begin
                busy_q[ren_addr] <= 1'b1;
                tag_q[ren_addr]  <= ren_tag;
            end
        end
    end

endmodule

// File: rtl/issue_dispatch_unit.sv
// Tomasulo issue stage: accepts one decoded instruction per cycle, allocates a
// ROB entry, checks RS capacity per class, renames rd and emits a registered
// dispatch packet with source tags. ROB pointers and RS counters live here.
// Optional feature macro: ISSUE_SAME_CYCLE_FREE_EN (same-cycle reuse of a slot
// freed by commit_valid / rs_rel; default build uses registered state only).
module issue_dispatch_unit
    import issue_pkg::*;
#(
    parameter int ROB_DEPTH    = DEF_ROB_DEPTH,
    parameter int NUM_REGS     = DEF_NUM_REGS,
    parameter int RS_PER_CLASS = 3,
    parameter int FUNC_W       = DEF_FUNC_W,
    localparam int IDX_W       = $clog2(ROB_DEPTH),
    localparam int REG_W       = $clog2(NUM_REGS)
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FUNC_W-1:0] in_func,
    input  logic [REG_W-1:0]  in_rs1,
    input  logic [REG_W-1:0]  in_rs2,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [2:0]        rs_rel,
    input  logic              commit_valid,
    input  logic              flush,
    output logic              disp_valid,
    output logic [1:0]        disp_class,
    output logic [FUNC_W-1:0] disp_func,
    output logic [IDX_W-1:0]  disp_rob_idx,
    output logic [IDX_W-1:0]  disp_rs1_tag,
    output logic              disp_rs1_busy,
    output logic [IDX_W-1:0]  disp_rs2_tag,
    output logic              disp_rs2_busy,
    output logic              illegal,
    output logic [IDX_W:0]    rob_count
);

    localparam int CNT_W = $clog2(RS_PER_CLASS + 1);
    localparam logic [CNT_W-1:0] RS_MAX = CNT_W'(RS_PER_CLASS);

    // ROB pointers carry an extra wrap bit to tell full from empty.
    logic [IDX_W:0]   head_ptr, tail_ptr;
    logic [IDX_W-1:0] head_idx, tail_idx;
    logic             rob_empty, rob_full;

    logic [CNT_W-1:0]       rs_cnt [NUM_CLASSES];
    logic [NUM_CLASSES-1:0] cls_full;
    logic [NUM_CLASSES-1:0] alloc_vec;

    logic [REG_W-1:0] rob_rd [ROB_DEPTH];

    issue_class_e in_cls;
    logic         in_illegal, rob_ok, cls_ok;
    logic         fire, legal_fire, illegal_fire, commit_fire, rename_en;

    logic             rat1_busy, rat2_busy;
    logic [IDX_W-1:0] rat1_tag, rat2_tag;
    logic             src1_busy, src2_busy;

    disp_pkt_t pkt_d, pkt_q;

    assign head_idx  = head_ptr[IDX_W-1:0];
    assign tail_idx  = tail_ptr[IDX_W-1:0];
    assign rob_empty = (head_ptr == tail_ptr);
    assign rob_full  = (head_idx == tail_idx) && (head_ptr[IDX_W] != tail_ptr[IDX_W]);
    assign rob_count = tail_ptr - head_ptr;

    assign in_cls     = func_class(in_func[3:0]);
    assign in_illegal = func_is_illegal(in_func[3:0]);

`ifdef ISSUE_SAME_CYCLE_FREE_EN
    assign rob_ok = !rob_full || commit_valid;
    assign cls_ok = !cls_full[in_cls] || rs_rel[in_cls];
`else
    assign rob_ok = !rob_full;
    assign cls_ok = !cls_full[in_cls];
`endif

    assign in_ready     = in_illegal || (rob_ok && cls_ok);
    assign fire         = in_valid && in_ready;
    assign legal_fire   = fire && !in_illegal;
    assign illegal_fire = fire && in_illegal;
    assign commit_fire  = commit_valid && !rob_empty;
    assign rename_en    = legal_fire && (in_cls != CLS_BCH);

    // A source produced by the entry retiring this cycle is already in the regfile.
    assign src1_busy = rat1_busy && !(commit_fire && (rat1_tag == head_idx));
    assign src2_busy = rat2_busy && !(commit_fire && (rat2_tag == head_idx));

    issue_rat #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .REG_W    (REG_W)
    ) u_rat (
        .clk1     (clk1),
        .rst      (rst),
        .flush    (flush),
        .rd1_addr (in_rs1),
        .rd1_busy (rat1_busy),
        .rd1_tag  (rat1_tag),
        .rd2_addr (in_rs2),
        .rd2_busy (rat2_busy),
        .rd2_tag  (rat2_tag),
        .ren_en   (rename_en),
        .ren_addr (in_rd),
        .ren_tag  (tail_idx),
        .clr_en   (commit_fire),
        .clr_addr (rob_rd[head_idx]),
        .clr_tag  (head_idx)
    );

    // Per-class fullness, one-hot allocation vector and the next dispatch packet.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        cls_full  = '0;
        alloc_vec = '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            cls_full[c] = (rs_cnt[c] >= RS_MAX);
        end
        if (legal_fire) begin
            alloc_vec[in_cls] = 1'b1;
        end
        pkt_d          = '0;
        pkt_d.cls      = in_cls;
        pkt_d.func     = PKT_FUNC_W'(in_func);
        pkt_d.rob_idx  = PKT_IDX_W'(tail_idx);
        pkt_d.rs1_tag  = PKT_IDX_W'(rat1_tag);
        pkt_d.rs1_busy = src1_busy;
        pkt_d.rs2_tag  = PKT_IDX_W'(rat2_tag);
        pkt_d.rs2_busy = src2_busy;
    end

    // ROB head/tail pointers; flush overrides both allocation and commit.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
        end else begin
            if (legal_fire)  tail_ptr <= tail_ptr + 1'b1;
            if (commit_fire) head_ptr <= head_ptr + 1'b1;
        end
    end

    // Destination register of each ROB entry, used to clear the RAT on commit.
    // NOTE: storage array without reset; an entry is only read after being written.
    always_ff @(posedge clk1) begin
        if (legal_fire) begin
            rob_rd[tail_idx] <= in_rd;
        end
    end

    // RS occupancy per class; simultaneous alloc and release cancel out.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CLASSES; c++) rs_cnt[c] <= '0;
        end else if (flush) begin
            for (int c = 0; c < NUM_CLASSES; c++) rs_cnt[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                if (alloc_vec[c] && !rs_rel[c]) begin
                    rs_cnt[c] <= rs_cnt[c] + 1'b1;
                end else if (!alloc_vec[c] && rs_rel[c] && (rs_cnt[c] != '0)) begin
                    rs_cnt[c] <= rs_cnt[c] - 1'b1;
                end
            end
        end
    end

    // Registered dispatch strobe, illegal pulse and packet.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            disp_valid <= 1'b0;
            illegal    <= 1'b0;
            pkt_q      <= '0;
        end else if (flush) begin
            disp_valid <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            disp_valid <= legal_fire;
            illegal    <= illegal_fire;
            if (legal_fire) pkt_q <= pkt_d;
        end
    end

    assign disp_class    = pkt_q.cls;
    assign disp_func     = pkt_q.func[FUNC_W-1:0];
    assign disp_rob_idx  = pkt_q.rob_idx[IDX_W-1:0];
    assign disp_rs1_tag  = pkt_q.rs1_tag[IDX_W-1:0];
    assign disp_rs1_busy = pkt_q.rs1_busy;
    assign disp_rs2_tag  = pkt_q.rs2_tag[IDX_W-1:0];
    assign disp_rs2_busy = pkt_q.rs2_busy;

endmodule

// File: tb/tb_issue_dispatch_unit.sv
// Self-checking bench for issue_dispatch_unit: directed vector table, hand
// sequences for RS-full / ROB-full / flush / async reset, then randomized
// traffic against a queue-based reference model.
module tb_issue_dispatch_unit;

    localparam int DEPTH = 8;
    localparam int RS_N  = 3;

    logic       clk1 = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_func;
    logic [3:0] in_rs1, in_rs2, in_rd;
    logic [2:0] rs_rel;
    logic       commit_valid;
    logic       flush;
    logic       disp_valid;
    logic [1:0] disp_class;
    logic [3:0] disp_func;
    logic [2:0] disp_rob_idx, disp_rs1_tag, disp_rs2_tag;
    logic       disp_rs1_busy, disp_rs2_busy;
    logic       illegal;
    logic [3:0] rob_count;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef ISSUE_SAME_CYCLE_FREE_EN
    localparam bit SAME_CYCLE = 1'b1;
`else
    localparam bit SAME_CYCLE = 1'b0;
`endif

    issue_dispatch_unit dut (
        .clk1          (clk1),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_func       (in_func),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .in_rd         (in_rd),
        .rs_rel        (rs_rel),
        .commit_valid  (commit_valid),
        .flush         (flush),
        .disp_valid    (disp_valid),
        .disp_class    (disp_class),
        .disp_func     (disp_func),
        .disp_rob_idx  (disp_rob_idx),
        .disp_rs1_tag  (disp_rs1_tag),
        .disp_rs1_busy (disp_rs1_busy),
        .disp_rs2_tag  (disp_rs2_tag),
        .disp_rs2_busy (disp_rs2_busy),
        .illegal       (illegal),
        .rob_count     (rob_count)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input bit v, input int f, input int a, input int b, input int d,
                         input int rel, input bit cm, input bit fl);
        in_valid     = v;
        in_func      = 4'(f);
        in_rs1       = 4'(a);
        in_rs2       = 4'(b);
        in_rd        = 4'(d);
        rs_rel       = 3'(rel);
        commit_valid = cm;
        flush        = fl;
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #3;
        rst = 1'b0;
        step();
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int idx;
        int rd;
        bit has_rd;
    } ent_t;

    ent_t m_rob[$];
    int   m_rs[3];
    int   m_tail;

    // 0 ADD, 1 MUL, 2 BCH, 3 illegal
    function automatic int cls_of(input int f);
        if (f >= 8) return 3;
        if (f >= 4) return 2;
        if (f >= 2) return 1;
        return 0;
    endfunction

    function automatic bit model_ready(input int f, input bit cm, input logic [2:0] rel);
        int  c;
        bit  rob_ok, cls_ok;
        c = cls_of(f);
        if (c == 3) return 1'b1;
        rob_ok = (m_rob.size() < DEPTH) || (SAME_CYCLE && cm);
        cls_ok = (m_rs[c] < RS_N) || (SAME_CYCLE && rel[c]);
        return rob_ok && cls_ok;
    endfunction

    // Youngest in-flight writer of r; it is ready if it is the head retiring now.
    task automatic lookup(input int r, input bit cfire, output bit busy, output int tag);
        busy = 1'b0;
        tag  = 0;
        for (int i = m_rob.size() - 1; i >= 0; i--) begin
            if (m_rob[i].has_rd && m_rob[i].rd == r) begin
                tag  = m_rob[i].idx;
                busy = !(cfire && i == 0);
                break;
            end
        end
    endtask

    task automatic model_clear();
        m_rob.delete();
        for (int c = 0; c < 3; c++) m_rs[c] = 0;
        m_tail = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit v; int f; int a; int b; int d; int rel; bit cm; bit fl;
        bit e_rdy; bit e_dv; int e_idx; bit e_b1; int e_t1; bit e_b2; int e_t2;
        bit e_ill; int e_cnt;
    } vec_t;

    vec_t vecs[9];

    initial begin
        bit  b1, b2, exp_rdy, fire, legal, cfire, e_dv, e_ill;
        int  t1, t2, c, e_idx, f;
        ent_t e;

        vecs[0] = '{1, 0, 1, 2, 3, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 1};
        vecs[1] = '{1, 2, 3, 3, 4, 0, 0, 0,  1, 1, 1, 1, 0, 1, 0, 0, 2};
        vecs[2] = '{1, 3, 3, 4, 5, 0, 1, 0,  1, 1, 2, 0, 0, 1, 1, 0, 2};
        vecs[3] = '{1, 10, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2};
        vecs[4] = '{0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 2};
        vecs[5] = '{1, 4, 5, 4, 3, 0, 0, 0,  1, 1, 3, 1, 2, 1, 1, 0, 3};
        vecs[6] = '{1, 0, 3, 0, 3, 0, 0, 0,  1, 1, 4, 0, 0, 0, 0, 0, 4};
        vecs[7] = '{1, 0, 1, 1, 1, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[8] = '{1, 1, 3, 4, 6, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 1};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        rst = 1'b0;
        step();

        // Reset state
        check("reset_in_ready", in_ready, 1);
        check("reset_disp_valid", disp_valid, 0);
        check("reset_illegal", illegal, 0);
        check("reset_rob_count", rob_count, 0);
        check("reset_rob_idx", disp_rob_idx, 0);

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].v, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].d,
                  vecs[i].rel, vecs[i].cm, vecs[i].fl);
            #1;
            check($sformatf("vec%0d_ready", i), in_ready, vecs[i].e_rdy);
            step();
            check($sformatf("vec%0d_disp_valid", i), disp_valid, vecs[i].e_dv);
            check($sformatf("vec%0d_illegal", i), illegal, vecs[i].e_ill);
            check($sformatf("vec%0d_rob_count", i), rob_count, vecs[i].e_cnt);
            if (vecs[i].e_dv) begin
                check($sformatf("vec%0d_rob_idx", i), disp_rob_idx, vecs[i].e_idx);
                check($sformatf("vec%0d_func", i), disp_func, vecs[i].f);
                check($sformatf("vec%0d_class", i), disp_class, cls_of(vecs[i].f));
                check($sformatf("vec%0d_rs1_busy", i), disp_rs1_busy, vecs[i].e_b1);
                check($sformatf("vec%0d_rs2_busy", i), disp_rs2_busy, vecs[i].e_b2);
                if (vecs[i].e_b1) check($sformatf("vec%0d_rs1_tag", i), disp_rs1_tag, vecs[i].e_t1);
                if (vecs[i].e_b2) check($sformatf("vec%0d_rs2_tag", i), disp_rs2_tag, vecs[i].e_t2);
            end
        end

        // ---- RS full: fourth ADD held until an ADD slot is released ----
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, i + 1, 0, 0, 0);
            step();
        end
        drive(1, 0, 0, 0, 4, 0, 0, 0);
        #1;
        check("rsfull_ready_low", in_ready, 0);
        step();
        check("rsfull_no_dispatch", disp_valid, 0);
        check("rsfull_rob_count", rob_count, 3);
        drive(1, 0, 0, 0, 4, 1, 0, 0);
        #1;
        check("rsfull_ready_on_release", in_ready, SAME_CYCLE);
        step();
        if (!SAME_CYCLE) begin
            check("rsfull_release_no_dispatch", disp_valid, 0);
            drive(1, 0, 0, 0, 4, 0, 0, 0);
            #1;
            check("rsfull_ready_after_release", in_ready, 1);
            step();
        end
        check("rsfull_dispatch", disp_valid, 1);
        check("rsfull_dispatch_idx", disp_rob_idx, 3);
        check("rsfull_count4", rob_count, 4);

        // ---- ROB full: 8 MUL/BCH with releases, then commit frees a slot ----
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, (i % 2 == 0) ? 2 : 4, 0, 0, i, 3'b110, 0, 0);
            step();
        end
        check("robfull_count", rob_count, DEPTH);
        drive(1, 2, 0, 0, 9, 0, 0, 0);
        #1;
        check("robfull_ready_low", in_ready, 0);
        drive(1, 2, 0, 0, 9, 0, 1, 0);
        #1;
        check("robfull_ready_on_commit", in_ready, SAME_CYCLE);
        step();
        if (!SAME_CYCLE) begin
            check("robfull_count_after_commit", rob_count, DEPTH - 1);
            drive(1, 2, 0, 0, 9, 0, 0, 0);
            #1;
            check("robfull_ready_after_commit", in_ready, 1);
            step();
        end
        check("robwrap_dispatch", disp_valid, 1);
        check("robwrap_idx", disp_rob_idx, 0);
        check("robwrap_count", rob_count, DEPTH);

        // ---- Fill 5 entries, flush, reissue ----
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, (i < 2) ? 0 : ((i < 4) ? 2 : 4), 0, 0, i + 1, 0, 0, 0);
            step();
        end
        check("flush_pre_count", rob_count, 5);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step();
        check("flush_count", rob_count, 0);
        check("flush_disp_valid", disp_valid, 0);
        drive(1, 2, 1, 2, 7, 0, 0, 0);
        step();
        check("flush_reissue_idx", disp_rob_idx, 0);
        check("flush_rs1_busy", disp_rs1_busy, 0);
        check("flush_rs2_busy", disp_rs2_busy, 0);

        // ---- Asynchronous reset mid-cycle ----
        drive(1, 0, 0, 0, 1, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_count", rob_count, 0);
        check("async_rst_disp_valid", disp_valid, 0);
        check("async_rst_ready", in_ready, 1);
        #1;
        rst = 1'b0;
        step();

        // ---- Randomized traffic against the reference model ----
        do_reset();
        model_clear();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            f = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
            drive($urandom_range(0, 3) != 0, f, $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 15),
                  {3{1'b0}} | {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                               ($urandom_range(0, 2) == 0)},
                  $urandom_range(0, 2) == 0, $urandom_range(0, 63) == 0);
            #1;
            exp_rdy = model_ready(f, commit_valid, rs_rel);
            check("rnd_ready", in_ready, exp_rdy);

            c     = cls_of(f);
            fire  = in_valid && exp_rdy;
            legal = fire && (c != 3);
            cfire = commit_valid && (m_rob.size() > 0);
            lookup(in_rs1, cfire, b1, t1);
            lookup(in_rs2, cfire, b2, t2);
            e_idx = m_tail;

            if (flush) begin
                e_dv  = 1'b0;
                e_ill = 1'b0;
                model_clear();
            end else begin
                e_dv  = legal;
                e_ill = fire && (c == 3);
                if (cfire) void'(m_rob.pop_front());
                if (legal) begin
                    e.idx    = m_tail;
                    e.rd     = in_rd;
                    e.has_rd = (c != 2);
                    m_rob.push_back(e);
                    m_tail = (m_tail + 1) % DEPTH;
                end
                for (int k = 0; k < 3; k++) begin
                    if (legal && c == k && !rs_rel[k]) m_rs[k]++;
                    else if (!(legal && c == k) && rs_rel[k] && m_rs[k] > 0) m_rs[k]--;
                end
            end

            step();
            check("rnd_disp_valid", disp_valid, e_dv);
            check("rnd_illegal", illegal, e_ill);
            check("rnd_rob_count", rob_count, m_rob.size());
            if (e_dv) begin
                check("rnd_rob_idx", disp_rob_idx, e_idx);
                check("rnd_class", disp_class, c);
                check("rnd_rs1_busy", disp_rs1_busy, b1);
                check("rnd_rs2_busy", disp_rs2_busy, b2);
                if (b1) check("rnd_rs1_tag", disp_rs1_tag, t1);
                if (b2) check("rnd_rs2_tag", disp_rs2_tag, t2);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
